// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, the load/store port and the RAM
// side of mem_arbiter into one interface.
//
// Handshake: a requester raises *_req with its address (and store data/mask)
// and holds all of them stable until it sees *_ack. *_ack is a one-cycle
// completion pulse. The requester drops *_req in the cycle after *_ack.
// Read data (*_rdata) is valid while *_ack is high and is held until the
// next ack on the same port. On the RAM side, mem_en is a one-cycle strobe.
// The RAM samples mem_addr, mem_wdata and mem_wmask on the edge that ends the
// mem_en cycle and returns mem_rdata in the following cycle.
//
// Modports:
//   slave  - the arbiter's view (requests in, acks/data out, RAM bus out)
//   master - the core/RAM-model view (the mirror image)
interface mem_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_rdata;
  logic              i_ack;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_wmask;
  logic [31:0]       d_rdata;
  logic              d_ack;

  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wmask;
  logic              mem_en;
  logic [31:0]       mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_wdata, d_wmask, mem_rdata,
    output i_rdata, i_ack, d_rdata, d_ack, mem_addr, mem_wdata, mem_wmask, mem_en
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, d_wdata, d_wmask, mem_rdata,
    input  i_rdata, i_ack, d_rdata, d_ack, mem_addr, mem_wdata, mem_wmask, mem_en
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, synchronous-read 32-bit word RAM
// between the instruction-fetch port (I, read-only) and the load/store port
// (D, read/write with byte mask). Every access is a fixed 4-cycle
// transaction IDLE -> ISSUE -> WAIT -> DONE. Simultaneous requests are
// served round-robin. After reset, I wins the first tie.
//
// Ports:
//   clk       - clock, rising edge
//   resetn    - synchronous, active-low reset
//   bus       - mem_arbiter_if.slave (I port, D port, RAM bus)
//   dbg_state - current FSM state (IDLE=0, ISSUE=1, WAIT=2, DONE=3)
module mem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          resetn,
  mem_arbiter_if.slave  bus,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic              last_grant_d;  // 1: D was granted last (reset value)
  logic              grant_d;       // winner of the transaction in flight
  logic              grant_wr;      // in-flight D access is a write
  logic              i_ack_q;
  logic              d_ack_q;
  logic [31:0]       i_rdata_q;
  logic [31:0]       d_rdata_q;
  logic              mem_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [3:0]        mem_wmask_q;
  logic              pick_d;

  // D wins when it is alone, or on a tie when I was granted last.
  assign pick_d = bus.d_req & (~bus.i_req | ~last_grant_d);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
      grant_d      <= 1'b0;
      grant_wr     <= 1'b0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_rdata_q    <= 32'd0;
      d_rdata_q    <= 32'd0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'd0;
      mem_wmask_q  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_req || bus.d_req) begin
            grant_d      <= pick_d;
            last_grant_d <= pick_d;
            mem_en_q     <= 1'b1;
            if (pick_d) begin
              mem_addr_q  <= bus.d_addr;
              mem_wdata_q <= bus.d_wdata;
              mem_wmask_q <= bus.d_wmask;
              grant_wr    <= |bus.d_wmask;
            end else begin
              mem_addr_q  <= bus.i_addr;
              mem_wmask_q <= 4'd0;
              grant_wr    <= 1'b0;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // The RAM takes the access on this edge. Drop the strobe and the
          // byte enables so nothing is written twice.
          mem_en_q    <= 1'b0;
          mem_wmask_q <= 4'd0;
          state       <= WAIT;
        end
        WAIT: begin
          if (grant_d) begin
            // A store leaves the last load value untouched.
            if (!grant_wr) begin
              d_rdata_q <= bus.mem_rdata;
            end
            d_ack_q <= 1'b1;
          end else begin
            i_rdata_q <= bus.mem_rdata;
            i_ack_q   <= 1'b1;
          end
          state <= DONE;
        end
        DONE: begin
          i_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.i_ack     = i_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wmask = mem_wmask_q;
  assign dbg_state     = state;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one single-ported, synchronous-read word RAM between the CPU instruction-fetch path (I-port, read-only) and the load/store path (D-port, read/write with byte mask). It sits between the SOC core state machine and the program/data memory, replacing direct `MEM[PC]` indexing once loads and stores are executed. Each access is a fixed 4-cycle transaction; simultaneous requests are served round-robin.

## Interface
- `ADDR_W`, default 8: word-address width; RAM depth is 2^ADDR_W words of 32 bits.
- `clk`  in  1  clock, all state updates on rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `i_req`  in  1  fetch request, held high until `i_ack`.
- `i_addr`  in  ADDR_W  fetch word address.
- `i_rdata`  out  32  fetch read data, valid when `i_ack`=1, held until the next I ack.
- `i_ack`  out  1  one-cycle completion pulse for the I-port.
- `d_req`  in  1  data request, held high until `d_ack`.
- `d_addr`  in  ADDR_W  data word address.
- `d_wdata`  in  32  store data.
- `d_wmask`  in  4  byte write enables; 0 = read, non-zero = write of the masked bytes.
- `d_rdata`  out  32  load data, valid when `d_ack`=1 for a read; unchanged by writes.
- `d_ack`  out  1  one-cycle completion pulse for the D-port.
- `mem_addr`  out  ADDR_W  RAM word address.
- `mem_wdata`  out  32  RAM write data.
- `mem_wmask`  out  4  RAM byte write enables (0 on reads).
- `mem_en`  out  1  RAM access strobe; RAM samples addr/wdata/wmask on the edge ending a cycle with `mem_en`=1.
- `mem_rdata`  in  32  RAM read data, valid in the cycle after the `mem_en` cycle.

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Sequence is always IDLE→ISSUE→WAIT→DONE→IDLE.
- IDLE: if no request, stay. Otherwise pick winner, latch its addr (and for D: wdata, wmask) into `mem_*` registers, set `mem_en`, record `last_grant`, go ISSUE.
- Arbitration: only I pending → I; only D pending → D; both pending → the port not equal to `last_grant`.
- ISSUE: `mem_en`=1 for exactly this cycle; on exit clear `mem_en` and `mem_wmask`; go WAIT.
- WAIT: at end of cycle, capture `mem_rdata` into winner's rdata register (D only if latched wmask was 0), assert winner's ack; go DONE.
- DONE: winner's ack high for this cycle only; requests are not sampled; go IDLE.
- Requester contract: drop req in the cycle after ack and keep addr/data stable from req until ack. Arbiter latches at grant, so changes after grant are ignored.
- Writes use identical sequencing and latency; `d_ack` still pulses; `d_rdata` keeps its previous value.
- Only one ack is ever high in a cycle; `i_ack` and `d_ack` are never simultaneously 1.

## Timing
- Reset (any edge with `resetn`=0): state IDLE, `last_grant`=D (so I wins the first tie), `i_ack`=`d_ack`=0, `i_rdata`=`d_rdata`=0, `mem_en`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wmask`=0. All outputs are registered.
- Latency: req sampled in IDLE cycle T → `mem_en` cycle T+1 → `mem_rdata` valid T+2 → ack and rdata visible T+3 → IDLE T+4.
- Max throughput: one transaction per 4 cycles. A request pending at T+4 is granted at T+4.
- A request rising during ISSUE/WAIT/DONE waits for the next IDLE. No request is lost while held.
- Reset mid-transaction: transaction abandoned, no ack is generated, and `last_grant` returns to D. A write whose ISSUE cycle already completed stays in RAM. Reset during IDLE with req high produces no grant that edge.
- Address wraps only by width; no range check.

## Test plan
- I read alone: RAM[5]=0xDEADBEEF, `i_req`=1, `i_addr`=5 at T → `mem_en`=1 with `mem_addr`=5 at T+1, `i_ack`=1 and `i_rdata`=0xDEADBEEF at T+3 only, `d_ack`=0 throughout.
- D byte write: RAM[7]=0x11223344, `d_wmask`=4'b0100, `d_wdata`=0x00AB0000 → `mem_wmask`=0100 at T+1, `d_ack` at T+3, `d_rdata` unchanged; a following I read of 7 returns 0x11AB3344.
- Tie after reset: `i_req` and `d_req` both high at first IDLE → `i_ack` at T+3, D granted at T+4, `d_ack` at T+7.
- Sustained contention: both reqs re-asserted immediately after each ack for 8 transactions → acks alternate I,D,I,D…, exactly 4 cycles apart, never overlapping.
- D write-then-read: write 0xCAFEF00D (mask 1111) to addr 3, then read addr 3 → `d_rdata`=0xCAFEF00D on second `d_ack`.
- Reset in WAIT: `resetn`=0 for one cycle during WAIT of an I read → no `i_ack`, all outputs 0 next cycle. After release, simultaneous reqs grant I first.
